// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 state dumper.
// Holds the FSM state encoding, the output tag codes and the machine word width.
package mips32_pkg;

  localparam int WORD_W = 32;

  // Tags that tell the sink where each streamed word came from
  localparam logic [1:0] TAG_REG = 2'b00;
  localparam logic [1:0] TAG_MEM = 2'b01;
  localparam logic [1:0] TAG_SUM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REG   = 3'd1,
    ST_MEM   = 3'd2,
    ST_TRAIL = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/mips32_state_dumper_if.sv
// Output stream of the state dumper: valid/ready handshake plus payload.
//   out_valid  source -> sink  payload below is valid
//   out_ready  sink -> source  sink accepts this cycle
//   out_data   dumped word or checksum
//   out_tag    word origin (register, memory, checksum)
//   out_index  source address of the word (0 for the checksum)
//   out_last   marks the checksum trailer
interface mips32_state_dumper_if;
  import mips32_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [1:0]        out_tag;
  logic [7:0]        out_index;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_tag, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_tag, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/mips32_state_dumper.sv
// Streams the register file, then data memory, then an XOR checksum trailer
// over a valid/ready output interface.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request a dump (only honoured in IDLE)
//   busy, done          busy while not IDLE; done pulses after the trailer transfers
//   reg_addr/reg_rdata  combinational register-file read port
//   mem_addr/mem_rdata  combinational data-memory read port
//   dump                output stream (master side)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_REG   | loading register words 0..REG_COUNT-1 into the output slot
// ST_MEM   | loading memory words 0..MEM_WORDS-1 into the output slot
// ST_TRAIL | loading the checksum trailer
// ST_FIN   | waiting for the trailer to transfer, then one done cycle
module mips32_state_dumper
  import mips32_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int MEM_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            reg_addr,
  input  logic [WORD_W-1:0]     reg_rdata,
  output logic [7:0]            mem_addr,
  input  logic [WORD_W-1:0]     mem_rdata,
  mips32_state_dumper_if.master dump
);

  localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);
  localparam logic [7:0] MEM_LAST = 8'(MEM_WORDS - 1);

  state_t            state, state_d;
  logic [7:0]        counter, counter_d;
  logic [WORD_W-1:0] checksum, checksum_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [1:0]        tag_q, tag_d;
  logic [7:0]        index_q, index_d;
  logic              last_q, last_d;
  logic              slot_free;

  // The slot may be reloaded when empty or when its current word leaves this edge
  assign slot_free = !valid_q || dump.out_ready;

  // Both read addresses follow the counter but are clamped to their own last
  // index, so neither port is ever addressed beyond the words it holds.
  assign reg_addr = (counter > REG_LAST) ? REG_LAST[4:0] : counter[4:0];
  assign mem_addr = (counter > MEM_LAST) ? MEM_LAST : counter;

  assign busy           = (state != ST_IDLE);
  assign done           = done_q;
  assign dump.out_valid = valid_q;
  assign dump.out_data  = data_q;
  assign dump.out_tag   = tag_q;
  assign dump.out_index = index_q;
  assign dump.out_last  = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      counter  <= '0;
      checksum <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      tag_q    <= TAG_REG;
      index_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_d;
      counter  <= counter_d;
      checksum <= checksum_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d    = state;
    counter_d  = counter;
    checksum_d = checksum;
    done_d     = 1'b0;
    valid_d    = valid_q;
    data_d     = data_q;
    tag_d      = tag_q;
    index_d    = index_q;
    last_d     = last_q;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_REG;
          counter_d  = '0;
          checksum_d = '0;
        end
      end

      ST_REG: begin
        if (slot_free) begin
          valid_d    = 1'b1;
          data_d     = reg_rdata;
          tag_d      = TAG_REG;
          index_d    = counter;
          last_d     = 1'b0;
          checksum_d = checksum ^ reg_rdata;
          if (counter == REG_LAST) begin
            state_d   = ST_MEM;
            counter_d = '0;
          end else begin
            counter_d = counter + 8'd1;
          end
        end
      end

      ST_MEM: begin
        if (slot_free) begin
          valid_d    = 1'b1;
          data_d     = mem_rdata;
          tag_d      = TAG_MEM;
          index_d    = counter;
          last_d     = 1'b0;
          checksum_d = checksum ^ mem_rdata;
          if (counter == MEM_LAST) begin
            state_d = ST_TRAIL;   // counter holds at the last index
          end else begin
            counter_d = counter + 8'd1;
          end
        end
      end

      ST_TRAIL: begin
        if (slot_free) begin
          valid_d = 1'b1;
          data_d  = checksum;
          tag_d   = TAG_SUM;
          index_d = '0;
          last_d  = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        // Stay here through the done cycle so a start coincident with done is ignored
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (valid_q && dump.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
